// File: rtl/bus_fifo_slave_pkg.sv
// Shared register map, STATUS bit positions and bus base address for the FIFO slave.
package bus_fifo_slave_pkg;

  typedef enum logic [2:0] {
    FIFO_DATA_IN  = 3'd0,
    FIFO_DATA_OUT = 3'd1,
    FIFO_POP      = 3'd2,
    FIFO_STATUS   = 3'd3,
    FIFO_CTRL     = 3'd4,
    FIFO_THRESH   = 3'd5,
    FIFO_RSVD6    = 3'd6,
    FIFO_RSVD7    = 3'd7
  } fifo_reg_e;

  localparam int unsigned ST_OVF   = 7;
  localparam int unsigned ST_UDF   = 6;
  localparam int unsigned ST_FULL  = 5;
  localparam int unsigned ST_EMPTY = 4;

  localparam int unsigned CTRL_IRQ_EN = 0;
  localparam int unsigned CTRL_CLEAR  = 1;

  localparam logic [15:0] FIFO_BASE_ADDR = 16'h0300;

endpackage

// File: rtl/bus_fifo_slave_mem.sv
// FIFO storage: synchronous write, asynchronous read, no reset.
module fifo_mem #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned PTR_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [PTR_WIDTH-1:0]  waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [PTR_WIDTH-1:0]  raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/bus_fifo_slave.sv
// Memory-mapped FIFO peripheral on the BUS slave side with sticky error flags
// and a programmable occupancy-threshold level interrupt.
module bus_fifo_slave
  import bus_fifo_slave_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  s_sel,
  input  logic                  s_wr,
  input  logic [ADDR_WIDTH-1:0] s_addr,
  input  logic [DATA_WIDTH-1:0] s_din,
  output logic [DATA_WIDTH-1:0] s_dout,
  output logic                  irq
);

  localparam int unsigned PTR_WIDTH = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);

  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  irq_en_q, irq_en_d;
  logic [CNT_WIDTH-1:0]  thresh_q, thresh_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  irq_q, irq_d;

  logic                  full, empty, mem_we;
  logic [DATA_WIDTH-1:0] head, rdata;
  fifo_reg_e             reg_sel;
  logic                  unused_addr;

  assign unused_addr = &{1'b0, s_addr[ADDR_WIDTH-1:3]};
  assign reg_sel     = fifo_reg_e'(s_addr[2:0]);
  assign full        = (count_q == FULL_CNT);
  assign empty       = (count_q == '0);

  fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .PTR_WIDTH (PTR_WIDTH)
  ) u_mem (
    .clk    (clk),
    .we_i   (mem_we),
    .waddr_i(wr_ptr_q),
    .wdata_i(s_din),
    .raddr_i(rd_ptr_q),
    .rdata_o(head)
  );

  // Read mux operates on pre-edge state; unmapped and write-only offsets read 0.
  always_comb begin
    rdata = '0;
    unique case (reg_sel)
      FIFO_DATA_OUT: rdata = empty ? '0 : head;
      FIFO_STATUS: begin
        rdata[ST_OVF]          = ovf_q;
        rdata[ST_UDF]          = udf_q;
        rdata[ST_FULL]         = full;
        rdata[ST_EMPTY]        = empty;
        rdata[CNT_WIDTH-1:0]   = count_q;
      end
      FIFO_CTRL:   rdata[CTRL_IRQ_EN]   = irq_en_q;
      FIFO_THRESH: rdata[CNT_WIDTH-1:0] = thresh_q;
      default:     rdata = '0;
    endcase
  end

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    irq_en_d = irq_en_q;
    thresh_d = thresh_q;
    mem_we   = 1'b0;
    dout_d   = (s_sel && !s_wr) ? rdata : '0;

    if (s_sel && s_wr) begin
      unique case (reg_sel)
        FIFO_DATA_IN: begin
          if (full) begin
            ovf_d = 1'b1;
          end else begin
            mem_we   = reset_n;
            wr_ptr_d = wr_ptr_q + 1'b1;
            count_d  = count_q + 1'b1;
          end
        end
        FIFO_POP: begin
          if (empty) begin
            udf_d = 1'b1;
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            count_d  = count_q - 1'b1;
          end
        end
        FIFO_STATUS: begin
          if (s_din[ST_OVF]) ovf_d = 1'b0;
          if (s_din[ST_UDF]) udf_d = 1'b0;
        end
        FIFO_CTRL: begin
          irq_en_d = s_din[CTRL_IRQ_EN];
          if (s_din[CTRL_CLEAR]) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
          end
        end
        FIFO_THRESH: thresh_d = s_din[CNT_WIDTH-1:0];
        default: ;
      endcase
    end

    irq_d = irq_en_d && (count_d >= thresh_d) && (thresh_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      irq_en_q <= 1'b0;
      thresh_q <= '0;
      dout_q   <= '0;
      irq_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      irq_en_q <= irq_en_d;
      thresh_q <= thresh_d;
      dout_q   <= dout_d;
      irq_q    <= irq_d;
    end
  end

  assign s_dout = dout_q;
  assign irq    = irq_q;

endmodule

// File: doc/bus_fifo_slave.md
Name: bus_fifo_slave

Overview:
- Memory-mapped FIFO peripheral on the slave side of the single-master BUS.
- Consumes the BUS slave outputs s_sel, s_wr, s_addr and s_din. Drives s_dout back to the BUS, which forwards it to the master as m_din.
- The master pushes 32-bit words, reads the head word, pops, and polls status.
- An optional level interrupt fires when occupancy reaches a programmable threshold.

Parameters:
DATA_WIDTH, 32, data word width
ADDR_WIDTH, 16, BUS address width
DEPTH, 8, FIFO entries (power of two, at least 2)
CNT_WIDTH, 4, occupancy counter width (log2(DEPTH)+1)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  synchronous active-low reset
s_sel  input  1  slave select from BUS, one access per cycle while high
s_wr  input  1  1 = write, 0 = read
s_addr  input  ADDR_WIDTH  address; only s_addr[2:0] is decoded
s_din  input  DATA_WIDTH  write data from BUS
s_dout  output  DATA_WIDTH  registered read data to BUS
irq  output  1  level interrupt

Behaviour:
- One clock (clk); reset is synchronous and active-low (reset_n).
- Reset effects, while reset_n=0 at a rising edge:
  - count, write pointer and read pointer become 0.
  - ovf, udf, irq_en, threshold and s_dout become 0.
  - irq becomes 0.
  - FIFO storage contents are don't-care.
- Reset mid-operation discards all entries; the access in that cycle is ignored.
- Register map (s_addr[2:0]):
  - 0 DATA_IN (W): push s_din.
  - 1 DATA_OUT (R): head entry, or 0 if empty; reading does not pop.
  - 2 POP (W): any write pops one entry.
  - 3 STATUS (R): {ovf[7], udf[6], full[5], empty[4], count[3:0]}, zero-extended. Writing 1 to bit7 or bit6 clears that bit (W1C).
  - 4 CTRL (R/W): bit0 irq_en. bit1 clear is write-only and self-clearing: it empties the FIFO and reads back 0.
  - 5 THRESH (R/W): bits[CNT_WIDTH-1:0].
  - 6, 7: reads return 0, writes are ignored.
- Writes take effect at the rising edge where s_sel=1 and s_wr=1. With s_sel=0 nothing changes.
- Read latency is 1 cycle:
  - At the edge where s_sel=1 and s_wr=0, s_dout captures the selected register's pre-edge value.
  - At every other edge, s_dout becomes 0.
- Push when full: data is dropped, pointers and count are unchanged, ovf is set to 1.
- Pop when empty: no change, udf is set to 1.
- ovf and udf are sticky until cleared by W1C or reset.
- CTRL clear sets count and both pointers to 0 and does not alter ovf or udf. When clear and irq_en are written together, irq_en takes the written value.
- Pointers wrap modulo DEPTH; count runs 0..DEPTH.
- full = (count == DEPTH); empty = (count == 0).
- A push and a pop cannot occur in the same cycle (single bus access per cycle), so count changes by at most ±1 per cycle.
- irq is registered: irq <= irq_en & (count >= threshold) & (threshold != 0), using post-update values, so it asserts 1 cycle after the causing write.
- The block has no state machine beyond pointer/count control; every access completes in one cycle and there are no wait states.

Decomposition:
- Shared constants file (included by the BUS top level and by benches):
  - register offsets: FIFO_DATA_IN=3'd0, FIFO_DATA_OUT=3'd1, FIFO_POP=3'd2, FIFO_STATUS=3'd3, FIFO_CTRL=3'd4, FIFO_THRESH=3'd5;
  - STATUS bit positions;
  - slave base address 16'h0300 for the BUS address decoder.
- One sub-module, fifo_mem: a DEPTH x DATA_WIDTH register array with synchronous write and asynchronous read port, indexed by the pointers.
- Control, decode and status logic stay in bus_fifo_slave.

Test Plan:
- Reset for 1 cycle, then read STATUS → s_dout=32'h0000_0010 one cycle later (empty, count 0); irq=0.
- Push 32'h0000_0002, 32'h0000_0004, 32'h0000_0006 → STATUS reads 32'h0000_0003. DATA_OUT reads 32'h0000_0002; after a POP write it reads 32'h0000_0004.
- Push 9 words 32'h11..32'h19 with DEPTH=8 → STATUS=32'h0000_00A8 (ovf, full, count 8). Popping all 8 returns 32'h11..32'h18 in order and pointers wrap. Then write STATUS 32'h80 → ovf clears.
- Pop on empty → STATUS=32'h0000_0050. Write 32'h40 to STATUS → 32'h0000_0010. Hold s_sel=0 with s_wr=1 and s_addr=0 → count stays 0.
- THRESH=3, CTRL=1, push 2 words → irq=0. Third push → irq=1 on the cycle after that write. POP → irq=0 one cycle later. CTRL=32'h3 → count 0 and irq=0.
- With 4 entries present, assert reset_n=0 during a push → next STATUS read = 32'h0000_0010 and irq=0.
